sync_fifo_prog: RTL
===================

Name: sync_fifo_prog

Overview:
- Parametrised synchronous FIFO that succeeds the fixed 16x8 FIFO. Width and depth are generalised.
- Adds programmable almost-full and almost-empty thresholds, an occupancy count output, and a selectable read mode: standard registered read or first-word-fall-through (FWFT).
- Adds sticky overflow/underflow error flags with a clear input.
- Sits between producer and consumer blocks in one clock domain and keeps the existing per-cycle handshake flags (wr_ack, overflow, underflow).

Parameters:
- FIFO_WIDTH, 16, data word width in bits (>=1).
- FIFO_DEPTH, 8, number of entries (>=2; need not be a power of two).
- FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through.
- CNT_W, $clog2(FIFO_DEPTH+1), derived width of count and threshold ports; must not be overridden.

Ports:
- clk  input  1  clock; all logic is rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- data_in  input  FIFO_WIDTH  write data.
- wr_en  input  1  write request.
- rd_en  input  1  read request.
- af_thresh  input  CNT_W  almost-full threshold, quasi-static.
- ae_thresh  input  CNT_W  almost-empty threshold, quasi-static.
- clr_sticky  input  1  clears the sticky error flags.
- data_out  output  FIFO_WIDTH  read data.
- count  output  CNT_W  current occupancy, 0..FIFO_DEPTH.
- full  output  1  count == FIFO_DEPTH.
- almostfull  output  1  count >= af_thresh.
- empty  output  1  count == 0.
- almostempty  output  1  count <= ae_thresh.
- wr_ack  output  1  registered pulse: previous-cycle write was accepted.
- overflow  output  1  registered pulse: previous-cycle write was rejected.
- underflow  output  1  registered pulse: previous-cycle read was rejected.
- ovf_sticky  output  1  latched overflow.
- udf_sticky  output  1  latched underflow.

Behaviour:
- Reset (async assert, sync deassert by the system):
  - wr_ptr, rd_ptr and count = 0.
  - data_out = 0, wr_ack, overflow, underflow, ovf_sticky, udf_sticky = 0.
  - empty = 1, full = 0; almost flags follow the thresholds with count 0.
  - Memory contents are not reset.
  - Reset mid-operation discards all contents immediately.
- Write acceptance: wr_accept = wr_en && (!full || rd_accept_std_full), where a write is accepted at full only if a read is accepted in the same cycle. Decided: when full and both wr_en and rd_en are asserted, both are accepted and count is unchanged.
- Read acceptance: rd_accept = rd_en && !empty. Decided: when empty and both are asserted, the write is accepted, the read is rejected (underflow=1 next cycle), and count becomes 1.
- Pointers:
  - wr_ptr / rd_ptr advance by 1 on accept.
  - They wrap from FIFO_DEPTH-1 to 0 via an explicit compare, not natural overflow.
- count: +1 on write only, -1 on read only, unchanged on both or neither.
- Flag timing:
  - full, empty, almostfull and almostempty are combinational from registered count and update the cycle after the accepting edge.
  - wr_ack, overflow and underflow are registered one-cycle pulses, asserted in the cycle after the request.
- Sticky flags:
  - ovf_sticky is set by any rejected write; udf_sticky is set by any rejected read.
  - clr_sticky clears both. If clr_sticky and a new error occur in the same cycle, set wins.
- FWFT=0 read mode:
  - data_out is registered and loaded with mem[rd_ptr] on the edge of an accepted read (1-cycle latency).
  - data_out holds otherwise, including on underflow.
- FWFT=1 read mode:
  - data_out = mem[rd_ptr] combinationally whenever !empty; rd_en pops the word.
  - When empty, data_out = 0.
  - A word written to an empty FIFO appears one cycle after the write edge.
- Thresholds are compared unsigned; values above FIFO_DEPTH are legal. For example, af_thresh = FIFO_DEPTH+1 means almostfull never asserts.

Decomposition:
- Package fifo_pkg:
  - fifo_mode_e enumeration (FIFO_STD, FIFO_FWFT).
  - A ptr_inc(ptr, depth) wrap function.
- Sub-module fifo_ram:
  - Simple dual-port RAM with 1 write and 1 asynchronous read port, parametrised FIFO_WIDTH/FIFO_DEPTH, no reset.
  - The top-level holds pointers, count, flags and the output register.

Test Plan:
1. Reset then fill (W=16, D=8, FWFT=0, af=6, ae=1): 8 writes of 0x0001..0x0008.
   - wr_ack on each; almostfull once count=6; full and count=8 after the 8th.
   - A 9th write gives overflow=1 next cycle, ovf_sticky=1, count stays 8.
2. Drain in order (FWFT=0): 8 reads.
   - data_out = 0x0001..0x0008, each 1 cycle after rd_en.
   - empty=1 after the last read.
   - An extra read gives underflow=1, udf_sticky=1, and data_out holds 0x0008.
3. Simultaneous read and write:
   - When full: count stays 8, wr_ack=1, no overflow, and the read returns the oldest word.
   - When empty: count becomes 1, underflow=1, wr_ack=1.
4. Wrap-around (D=6, non-power-of-two): 20 interleaved write/read pairs.
   - Data order is preserved across pointer wrap at 5 -> 0; count stays 0..1.
5. FWFT=1: write 0xABCD into an empty FIFO.
   - data_out = 0xABCD and empty=0 one cycle later, with no rd_en.
   - rd_en pops it, giving empty=1 and data_out=0 next cycle.
6. Sticky and reset:
   - clr_sticky coinciding with overflow leaves ovf_sticky=1.
   - Asserting rst_n=0 mid-fill at count=5 gives count=0, empty=1 and sticky flags=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/sync_fifo_prog_pkg.sv
// Shared types and helpers for the programmable synchronous FIFO.
package fifo_pkg;

  typedef enum logic [0:0] {
    FIFO_STD,
    FIFO_FWFT
  } fifo_mode_e;

  // Wraps by explicit compare so non-power-of-two depths work.
  function automatic int unsigned ptr_inc(int unsigned ptr, int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_prog_if.sv
// Producer/consumer-facing signal bundle of the programmable FIFO.
interface sync_fifo_prog_if #(
  parameter int unsigned FIFO_WIDTH = 16,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1)
);
  logic [FIFO_WIDTH-1:0] data_in;
  logic                  wr_en;
  logic                  rd_en;
  logic [CNT_W-1:0]      af_thresh;
  logic [CNT_W-1:0]      ae_thresh;
  logic                  clr_sticky;
  logic [FIFO_WIDTH-1:0] data_out;
  logic [CNT_W-1:0]      count;
  logic                  full;
  logic                  almostfull;
  logic                  empty;
  logic                  almostempty;
  logic                  wr_ack;
  logic                  overflow;
  logic                  underflow;
  logic                  ovf_sticky;
  logic                  udf_sticky;

  modport master (
    output data_in, wr_en, rd_en, af_thresh, ae_thresh, clr_sticky,
    input  data_out, count, full, almostfull, empty, almostempty,
    input  wr_ack, overflow, underflow, ovf_sticky, udf_sticky
  );

  modport slave (
    input  data_in, wr_en, rd_en, af_thresh, ae_thresh, clr_sticky,
    output data_out, count, full, almostfull, empty, almostempty,
    output wr_ack, overflow, underflow, ovf_sticky, udf_sticky
  );
endinterface

// File: rtl/sync_fifo_prog_ram.sv
// Storage for the FIFO: one synchronous write port, one asynchronous read port, no reset.
module fifo_ram #(
  parameter int unsigned FIFO_WIDTH = 16,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned AddrW      = $clog2(FIFO_DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [AddrW-1:0]      waddr_i,
  input  logic [FIFO_WIDTH-1:0] wdata_i,
  input  logic [AddrW-1:0]      raddr_i,
  output logic [FIFO_WIDTH-1:0] rdata_o
);

  logic [FIFO_WIDTH-1:0] mem_q [FIFO_DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_prog.sv
// Parametrised synchronous FIFO with programmable thresholds, sticky errors and FWFT option.
module sync_fifo_prog
  import fifo_pkg::*;
#(
  parameter int unsigned FIFO_WIDTH = 16,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned FWFT       = 0,
  parameter int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  sync_fifo_prog_if.slave bus
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam fifo_mode_e  Mode = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;

  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [FIFO_WIDTH-1:0] dout_q, dout_d;
  logic                  wr_ack_q, ovf_q, udf_q, ovf_sticky_q, udf_sticky_q;
  logic                  ovf_sticky_d, udf_sticky_d;
  logic                  full_w, empty_w, wr_accept, rd_accept, wr_reject, rd_reject;
  logic [FIFO_WIDTH-1:0] rdata;

  assign full_w  = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty_w = (count_q == '0);

  // A write at full is only taken when a read frees the slot in the same cycle.
  assign rd_accept = bus.rd_en && !empty_w;
  assign wr_accept = bus.wr_en && (!full_w || rd_accept);
  assign wr_reject = bus.wr_en && !wr_accept;
  assign rd_reject = bus.rd_en && !rd_accept;

  always_comb begin
    wr_ptr_d = wr_accept ? PtrW'(ptr_inc(32'(wr_ptr_q), FIFO_DEPTH)) : wr_ptr_q;
    rd_ptr_d = rd_accept ? PtrW'(ptr_inc(32'(rd_ptr_q), FIFO_DEPTH)) : rd_ptr_q;
    count_d  = count_q;
    case ({wr_accept, rd_accept})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    dout_d       = rd_accept ? rdata : dout_q;
    ovf_sticky_d = wr_reject ? 1'b1 : (bus.clr_sticky ? 1'b0 : ovf_sticky_q);
    udf_sticky_d = rd_reject ? 1'b1 : (bus.clr_sticky ? 1'b0 : udf_sticky_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      dout_q       <= '0;
      wr_ack_q     <= 1'b0;
      ovf_q        <= 1'b0;
      udf_q        <= 1'b0;
      ovf_sticky_q <= 1'b0;
      udf_sticky_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      dout_q       <= dout_d;
      wr_ack_q     <= wr_accept;
      ovf_q        <= wr_reject;
      udf_q        <= rd_reject;
      ovf_sticky_q <= ovf_sticky_d;
      udf_sticky_q <= udf_sticky_d;
    end
  end

  fifo_ram #(
    .FIFO_WIDTH (FIFO_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH),
    .AddrW      (PtrW)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (wr_accept),
    .waddr_i (wr_ptr_q),
    .wdata_i (bus.data_in),
    .raddr_i (rd_ptr_q),
    .rdata_o (rdata)
  );

  // FWFT exposes the head word directly; registered mode only updates on a pop.
  assign bus.data_out    = (Mode == FIFO_FWFT) ? (empty_w ? '0 : rdata) : dout_q;
  assign bus.count       = count_q;
  assign bus.full        = full_w;
  assign bus.empty       = empty_w;
  assign bus.almostfull  = (count_q >= bus.af_thresh);
  assign bus.almostempty = (count_q <= bus.ae_thresh);
  assign bus.wr_ack      = wr_ack_q;
  assign bus.overflow    = ovf_q;
  assign bus.underflow   = udf_q;
  assign bus.ovf_sticky  = ovf_sticky_q;
  assign bus.udf_sticky  = udf_sticky_q;

endmodule
